// File: rtl/ark_pkg.sv
// ark_pkg: shared constants and beat type for the AddRoundKey stream pipe.
package ark_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned AES_IDX_W       = 4;
  localparam int unsigned AES128_NUM_KEYS = 11;
  localparam int unsigned AES192_NUM_KEYS = 13;
  localparam int unsigned AES256_NUM_KEYS = 15;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] data;
    logic [AES_IDX_W-1:0]   round;
    logic                   err;
  } ark_beat_t;

endpackage

// File: rtl/ark_pipe_stage.sv
// ark_pipe_stage: one valid/ready register slice; bubbles collapse.
module ark_pipe_stage
  import ark_pkg::*;
#(
  parameter int unsigned W = AES_BLOCK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Slot can take a beat when empty or when its current beat leaves this cycle.
  assign up_ready = !valid_q || dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  // Slot register: load on accepted beat, drop valid when drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/ark_stream_pipe.sv
// ark_stream_pipe: round-key bank plus PIPE_STAGES-deep AddRoundKey pipeline.
// Optional macro ARK_MASK_EN adds in_mask/out_mask (data ^ key ^ mask, mask carried).
module ark_stream_pipe
  import ark_pkg::*;
#(
  parameter int unsigned DATA_W      = AES_BLOCK_W,
  parameter int unsigned NUM_KEYS    = AES128_NUM_KEYS,
  parameter int unsigned IDX_W       = AES_IDX_W,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [IDX_W-1:0]  key_addr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
`ifdef ARK_MASK_EN
  input  logic [DATA_W-1:0] in_mask,
  output logic [DATA_W-1:0] out_mask,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_round,
  output logic              out_err
);

  typedef struct packed {
`ifdef ARK_MASK_EN
    logic [DATA_W-1:0] mask;
`endif
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  round;
    logic              err;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  logic [DATA_W-1:0] bank [NUM_KEYS];
  logic [DATA_W-1:0] key_sel;
  logic              key_hit;
  beat_t             in_beat;

  logic [PIPE_STAGES:0] stg_valid;
  logic [PIPE_STAGES:0] stg_ready;
  logic [BEAT_W-1:0]    stg_data [PIPE_STAGES+1];
  beat_t                last_beat;

  // Key bank: address decode by match, so out-of-range writes hit no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        bank[i] <= '0;
      end
    end else if (key_we) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (key_addr == IDX_W'(i)) begin
          bank[i] <= key_wdata;
        end
      end
    end
  end

  // Key lookup from registered bank (read-before-write); miss yields zero key.
  always_comb begin
    key_sel = '0;
    key_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (in_round == IDX_W'(i)) begin
        key_sel = bank[i];
        key_hit = 1'b1;
      end
    end
  end

  // Beat entering stage 0.
  always_comb begin
    in_beat       = '0;
`ifdef ARK_MASK_EN
    in_beat.mask  = in_mask;
    in_beat.data  = in_data ^ key_sel ^ in_mask;
`else
    in_beat.data  = in_data ^ key_sel;
`endif
    in_beat.round = in_round;
    in_beat.err   = !key_hit;
  end

  assign stg_valid[0]           = in_valid;
  assign stg_data[0]            = in_beat;
  assign in_ready               = stg_ready[0];
  assign stg_ready[PIPE_STAGES] = out_ready;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    ark_pipe_stage #(
      .W (BEAT_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (stg_valid[s]),
      .up_ready (stg_ready[s]),
      .up_data  (stg_data[s]),
      .dn_valid (stg_valid[s+1]),
      .dn_ready (stg_ready[s+1]),
      .dn_data  (stg_data[s+1])
    );
  end

  assign last_beat = stg_data[PIPE_STAGES];
  assign out_valid = stg_valid[PIPE_STAGES];
  assign out_data  = last_beat.data;
  assign out_round = last_beat.round;
  assign out_err   = last_beat.err;
`ifdef ARK_MASK_EN
  assign out_mask  = last_beat.mask;
`endif

endmodule

// File: tb/tb_ark_stream_pipe.sv
// tb_ark_stream_pipe: randomized stimulus against a queue/array reference model.
// Honours ARK_MASK_EN when defined.
module tb_ark_stream_pipe;

  localparam int unsigned DW = 128;
  localparam int unsigned NK = 11;
  localparam int unsigned IW = 4;
  localparam int unsigned P  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          key_we;
  logic [IW-1:0] key_addr;
  logic [DW-1:0] key_wdata;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_round;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_round;
  logic          out_err;
`ifdef ARK_MASK_EN
  logic [DW-1:0] in_mask;
  logic [DW-1:0] out_mask;
`endif

  always #5 clk = ~clk;

  ark_stream_pipe #(
    .DATA_W      (DW),
    .NUM_KEYS    (NK),
    .IDX_W       (IW),
    .PIPE_STAGES (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_round  (in_round),
`ifdef ARK_MASK_EN
    .in_mask   (in_mask),
    .out_mask  (out_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_round (out_round),
    .out_err   (out_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: key array plus FIFO of expected beats.
  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [IW-1:0] round;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [DW-1:0] mbank [NK];
  int            cyc = 0;
  bit            strict = 1'b0;
  bit            hold = 1'b0;
  logic [DW-1:0] h_data;
  logic [DW-1:0] h_mask;
  logic [IW-1:0] h_round;
  logic          h_err;

  // Compare process: values at the falling edge are what the next rising edge sees.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < int'(NK); i++) mbank[i] = '0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", DW'(out_valid), DW'(1));
        chk("stall_data", out_data, h_data);
        chk("stall_round", DW'(out_round), DW'(h_round));
        chk("stall_err", DW'(out_err), DW'(h_err));
`ifdef ARK_MASK_EN
        chk("stall_mask", out_mask, h_mask);
`endif
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", DW'(out_valid), DW'(0));
        end else begin
          e = q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_round", DW'(out_round), DW'(e.round));
          chk("beat_err", DW'(out_err), DW'(e.err));
`ifdef ARK_MASK_EN
          chk("beat_mask", out_mask, e.mask);
`endif
          if (strict) chk("latency", DW'(cyc - e.cyc), DW'(P));
          else        chk("latency_min", DW'(cyc - e.cyc >= int'(P)), DW'(1));
        end
      end
      if (strict) chk("in_ready_stream", DW'(in_ready), DW'(1));
      if (in_valid && in_ready) begin
        e.round = in_round;
        e.err   = int'(in_round) >= int'(NK);
        e.data  = in_data;
        e.mask  = '0;
        e.cyc   = cyc;
        if (!e.err) e.data = in_data ^ mbank[in_round];
`ifdef ARK_MASK_EN
        e.mask  = in_mask;
        e.data  = e.data ^ in_mask;
`endif
        q.push_back(e);
      end
      if (key_we && int'(key_addr) < int'(NK)) mbank[key_addr] = key_wdata;
      hold    = out_valid && !out_ready;
      h_data  = out_data;
      h_round = out_round;
      h_err   = out_err;
      h_mask  = '0;
`ifdef ARK_MASK_EN
      h_mask  = out_mask;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    key_we    = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    tick();
    chk("drain_empty", DW'(q.size()), DW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  logic [DW-1:0] k1, k2, dd;

  initial begin
    key_we = 1'b0; key_addr = '0; key_wdata = '0;
    in_valid = 1'b0; in_data = '0; in_round = '0; out_ready = 1'b1;
`ifdef ARK_MASK_EN
    in_mask = '0;
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", DW'(out_valid), DW'(0));
    chk("reset_out_data", out_data, '0);
    chk("reset_out_round", DW'(out_round), DW'(0));
    chk("reset_out_err", DW'(out_err), DW'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_reset", DW'(in_ready), DW'(1));

    // Load the key bank.
    for (int i = 0; i < int'(NK); i++) begin
      key_we    = 1'b1;
      key_addr  = IW'(i);
      key_wdata = (i == 3) ? 128'h000102030405060708090a0b0c0d0e0f : rnd();
      tick();
    end
    key_we = 1'b0;

    // Known-answer beat on round 3.
    in_valid = 1'b1;
    in_data  = 128'h00112233445566778899aabbccddeeff;
    in_round = 4'd3;
    chk("kat_in_ready", DW'(in_ready), DW'(1));
    tick();
    in_valid = 1'b0;
    repeat (P - 2) tick();
    chk("kat_early_valid", DW'(out_valid), DW'(0));
    tick();
    chk("kat_valid", DW'(out_valid), DW'(1));
    chk("kat_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("kat_round", DW'(out_round), DW'(3));
    chk("kat_err", DW'(out_err), DW'(0));
    drain();

    // Full-rate stream, downstream always ready.
    strict = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      in_valid  = 1'b1;
      in_data   = rnd();
      in_round  = IW'($urandom_range(NK - 1));
      key_we    = ($urandom_range(19) == 0);
      key_addr  = IW'($urandom_range(15));
      key_wdata = rnd();
`ifdef ARK_MASK_EN
      in_mask   = rnd();
`endif
      tick();
    end
    drain();
    strict = 1'b0;

    // Random backpressure, sparse input, any round index.
    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(99) < 70);
      in_data   = rnd();
      in_round  = IW'($urandom_range(15));
      out_ready = 1'($urandom_range(1));
      key_we    = ($urandom_range(29) == 0);
      key_addr  = IW'($urandom_range(15));
      key_wdata = rnd();
`ifdef ARK_MASK_EN
      in_mask   = rnd();
`endif
      tick();
    end
    drain();
`ifdef ARK_MASK_EN
    in_mask = '0;
`endif

    // Out-of-range round and out-of-range key write.
    key_we    = 1'b1;
    key_addr  = 4'd12;
    key_wdata = '1;
    in_valid  = 1'b1;
    in_data   = {16{8'hA5}};
    in_round  = 4'd12;
    tick();
    key_we   = 1'b0;
    in_valid = 1'b0;
    repeat (P - 1) tick();
    chk("oor_valid", DW'(out_valid), DW'(1));
    chk("oor_data", out_data, {16{8'hA5}});
    chk("oor_round", DW'(out_round), DW'(12));
    chk("oor_err", DW'(out_err), DW'(1));
    tick();
    for (int r = 0; r < int'(NK); r++) begin
      in_valid = 1'b1;
      in_data  = rnd();
      in_round = IW'(r);
      tick();
    end
    drain();

    // Same-cycle key write and lookup on round 2.
    k1 = rnd(); k2 = rnd(); dd = rnd();
    key_we = 1'b1; key_addr = 4'd2; key_wdata = k1;
    tick();
    key_wdata = k2; in_valid = 1'b1; in_round = 4'd2; in_data = dd;
    tick();
    key_we = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (P - 2) tick();
    chk("rbw_old_key", out_data, dd ^ k1);
    tick();
    chk("rbw_new_key", out_data, dd ^ k2);
    drain();

    // Fill the pipe, then reset with beats in flight.
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_data  = rnd();
      in_round = IW'($urandom_range(NK - 1));
      tick();
    end
    in_valid = 1'b0;
    chk("full_out_valid", DW'(out_valid), DW'(1));
    chk("full_in_ready", DW'(in_ready), DW'(0));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", DW'(out_valid), DW'(0));
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_err", DW'(out_err), DW'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", DW'(in_ready), DW'(1));
    out_ready = 1'b1;
    dd        = rnd();
    in_valid  = 1'b1;
    in_round  = 4'd0;
    in_data   = dd;
    tick();
    in_valid = 1'b0;
    repeat (P - 1) tick();
    chk("postrst_valid", DW'(out_valid), DW'(1));
    chk("postrst_data", out_data, dd);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ark_stream_pipe.md
Name: ark_stream_pipe

Overview:
- Parametrised, streaming successor to the single-stage AddRoundKey XOR.
- Holds a bank of NUM_KEYS round keys loaded through a write port.
- Accepts data beats tagged with a round index and emits data XOR key[round] through a PIPE_STAGES-deep valid/ready pipeline.
- Sits between the round datapath (SubBytes/ShiftRows/MixColumns) and the round controller of the iterative AES core.

Parameters:
- DATA_W, 128, data and key width in bits.
- NUM_KEYS, 11, round-key bank depth; 11 for AES-128, 15 for AES-256.
- IDX_W, 4, round-index width; must satisfy 2**IDX_W >= NUM_KEYS.
- PIPE_STAGES, 1, register stages from input to output; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_we  in  1  key-bank write strobe.
- key_addr  in  IDX_W  key-bank write address.
- key_wdata  in  DATA_W  round key to store.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  state to combine with the key.
- in_round  in  IDX_W  round index selecting the bank entry.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  in_data XOR key[in_round].
- out_round  out  IDX_W  round index carried with the beat.
- out_err  out  1  beat used an out-of-range index.

Behaviour:
- Reset: asynchronous on rst_n low. Clears all key-bank entries, stage data and valid bits.
  - out_valid=0, out_data=0, out_round=0, out_err=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- Key bank write: on a clk edge with key_we=1 and key_addr<NUM_KEYS, store key_wdata.
  - Writes with key_addr>=NUM_KEYS are ignored.
- Input handshake: a beat is accepted when in_valid and in_ready are both 1 at a clk edge.
  - Key lookup uses bank contents before any same-cycle write (read-before-write).
  - When in_round>=NUM_KEYS: data passes with key 0x0 and the beat's err tag is set to 1.
- Pipeline:
  - Each stage holds {valid, data, round, err}. Stage 0 registers the XOR result.
  - A stage advances when the next stage is empty or is advancing itself.
  - in_ready = !stage0_valid || stage0_advancing. Bubbles collapse.
  - in_ready must not combinationally depend on in_valid.
- Latency: PIPE_STAGES cycles from acceptance to out_valid with out_ready held at 1.
  - Throughput is one beat per cycle.
- Output: out_valid/out_data/out_round/out_err driven directly from the last stage register.
  - With out_valid=1 and out_ready=0, all out_* hold stable until accepted.
- Full condition: all stages valid and out_ready=0 gives in_ready=0.
  - No beat is dropped or duplicated.
- Simultaneous accept and output: with all stages full and out_ready=1, the pipeline shifts and accepts a new beat in the same cycle.
- Reset mid-operation: in-flight beats are discarded and key-bank contents are lost. The bank must be reloaded.

Optional Feature:
- Macro: ARK_MASK_EN.
- Defined:
  - Adds input in_mask and output out_mask, both DATA_W wide.
  - Stage 0 computes in_data ^ key ^ in_mask. in_mask itself is carried unchanged alongside the beat as out_mask.
  - Downstream unmasks with out_data ^ out_mask. This supports first-order Boolean masking experiments for the side-channel study.
- Undefined: the ports do not exist and no mask registers are built.

Decomposition:
- Shared package ark_pkg holds:
  - AES_BLOCK_W=128.
  - Key-bank depth constants for AES-128/192/256 (11/13/15).
  - A beat struct/typedef {data, round, err}.
- Natural sub-module: ark_pipe_stage, a single valid/ready register slice instantiated PIPE_STAGES times via generate.
- The key bank stays inline.

Test Plan:
- Load key[3]=0x000102030405060708090a0b0c0d0e0f; send in_data=0x00112233445566778899aabbccddeeff, in_round=3 -> out_data=0x00102030405060708090a0b0c0d0e0f0, out_round=3, out_err=0 after PIPE_STAGES cycles.
- 1000 random beats with random in_round<NUM_KEYS and out_ready=1 -> every beat matches in_data^key[in_round], one beat per cycle, order preserved.
- Random out_ready toggling (~50%) with PIPE_STAGES=3 -> no loss or duplication; out_* stable while out_valid=1 and out_ready=0.
- in_round=12 with NUM_KEYS=11 and in_data=0xA5..A5 -> out_data=0xA5..A5, out_err=1; key_we with key_addr=12 leaves the bank unchanged.
- key_we to addr 2 in the same cycle as accepting a round-2 beat -> the beat uses the old key; the next round-2 beat uses the new key.
- Assert rst_n=0 while 3 beats are in flight -> out_valid=0 immediately; a beat sent after release with round 0 returns in_data^0.
